register_file: RTL and testbench

//   MIPS-style general-purpose register file for the CPU datapath, directly downstream of
//   the 2:1 muxes that pick the write-back data (ALU result vs memory) and the destination

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/register_file.sv | 87 ++++++++
 tb/tb_register_file.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath definitions.
//   WORD_W / IDX_W : default data width and register index width
//   word_t         : one datapath word
//   reg_idx_t      : register file index
//   REG_ZERO       : hardwired-zero register
//   REG_SP         : stack pointer by software convention
//   REG_RA         : link register written by jal
`ifndef CPU_PKG_SV
`define CPU_PKG_SV

package cpu_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned IDX_W  = 5;

   localparam int unsigned REG_ZERO = 0;
   localparam int unsigned REG_SP   = 29;
   localparam int unsigned REG_RA   = 31;

   typedef logic [IDX_W-1:0]  reg_idx_t;
   typedef logic [WORD_W-1:0] word_t;

endpackage

`endif // CPU_PKG_SV

// File: rtl/register_file.sv
// register_file: general-purpose register file for the CPU datapath.
//   Two combinational read ports, one synchronous write port, register 0 reads as zero,
//   and a same-cycle write-to-read bypass so a value written this cycle is visible
//   on the read ports before the clock edge.
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset; clears every register, beats a write
//   regWrite   write enable
//   writeReg   destination register index
//   writeData  write-back data
//   readReg1   source index, port 1 (rs)
//   readReg2   source index, port 2 (rt)
//   readData1  contents of readReg1 (bypassed)
//   readData2  contents of readReg2 (bypassed)
`ifndef REGISTER_FILE_SV
`define REGISTER_FILE_SV

module register_file
   import cpu_pkg::*;
#(
   parameter int unsigned n = 32,
   parameter int unsigned r = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         regWrite,
   input  logic [r-1:0] writeReg,
   input  logic [n-1:0] writeData,
   input  logic [r-1:0] readReg1,
   input  logic [r-1:0] readReg2,
   output logic [n-1:0] readData1,
   output logic [n-1:0] readData2
);

   localparam int depth = 1 << r;
   localparam logic [r-1:0] zero_idx = r'(REG_ZERO);

   logic [n-1:0] mem [depth];

   // A write only takes effect (and only bypasses) when not in reset and not aimed at r0.
   logic wr_fire;
   assign wr_fire = regWrite && !rst && (writeReg != zero_idx);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < depth; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_fire) begin
         mem[writeReg] <= writeData;
      end
   end

   // Both read ports share one read/bypass path.
   logic [r-1:0] rd_idx  [2];
   logic [n-1:0] rd_data [2];

   assign rd_idx[0] = readReg1;
   assign rd_idx[1] = readReg2;

   for (genvar k = 0; k < 2; k++) begin : g_port
      always_comb begin
         rd_data[k] = '0;
         if (rd_idx[k] == zero_idx) begin
            rd_data[k] = '0;
         end else if (wr_fire && (writeReg == rd_idx[k])) begin
            rd_data[k] = writeData;
         end else begin
            rd_data[k] = mem[rd_idx[k]];
         end
      end
   end

   assign readData1 = rd_data[0];
   assign readData2 = rd_data[1];

   // An unknown destination with the write enabled would scribble an unknown register.
   always_ff @(posedge clk) begin
      if (!rst && regWrite) begin
         assert (!$isunknown(writeReg))
         else $error("register_file: regWrite with unknown writeReg");
      end
   end

endmodule

`endif // REGISTER_FILE_SV

// File: tb/tb_register_file.sv
module tb_register_file;
   import cpu_pkg::*;

   logic     clk = 1'b0;
   logic     rst;
   logic     regWrite;
   reg_idx_t writeReg;
   word_t    writeData;
   reg_idx_t readReg1;
   reg_idx_t readReg2;
   word_t    readData1;
   word_t    readData2;

   int errors = 0;
   int checks = 0;

   word_t model [32];

   always #5 clk = ~clk;

   register_file #(
      .n(32),
      .r(5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .regWrite  (regWrite),
      .writeReg  (writeReg),
      .writeData (writeData),
      .readReg1  (readReg1),
      .readReg2  (readReg2),
      .readData1 (readData1),
      .readData2 (readData2)
   );

   task automatic check_eq(input string tag, input word_t got, input word_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected read value for the inputs currently applied.
   function automatic word_t model_read(input reg_idx_t idx);
      if (idx == 0) return '0;
      if (regWrite && !rst && writeReg != 0 && writeReg == idx) return writeData;
      return model[idx];
   endfunction

   task automatic set_in(input logic rs, input logic we, input reg_idx_t wr, input word_t wd,
                         input reg_idx_t a1, input reg_idx_t a2);
      rst       = rs;
      regWrite  = we;
      writeReg  = wr;
      writeData = wd;
      readReg1  = a1;
      readReg2  = a2;
      #3;
   endtask

   // Clock edge: update the model from the inputs held across the edge.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) model[i] = '0;
      end else if (regWrite && writeReg != 0) begin
         model[writeReg] = writeData;
      end
      #1;
   endtask

   task automatic write_reg(input reg_idx_t wr, input word_t wd);
      set_in(1'b0, 1'b1, wr, wd, 5'd0, 5'd0);
      tick();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = '0;
      set_in(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0);
      @(posedge clk);
      #1;

      // Initial reset
      set_in(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0);
      tick();

      // 1. fill then reset: everything reads zero on both ports
      for (int i = 1; i < 32; i++) write_reg(reg_idx_t'(i), 32'hA5A5_0000 + i);
      set_in(1'b0, 1'b0, 5'd0, '0, 5'd17, 5'd31);
      check_eq("fill_p1", readData1, 32'hA5A5_0011);
      check_eq("fill_p2", readData2, 32'hA5A5_001F);
      set_in(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0);
      tick();
      for (int i = 0; i < 32; i++) begin
         set_in(1'b0, 1'b0, 5'd0, '0, reg_idx_t'(i), reg_idx_t'(31 - i));
         check_eq("reset_p1", readData1, 32'h0);
         check_eq("reset_p2", readData2, 32'h0);
      end

      // 2. basic write / read
      write_reg(5'd8, 32'hDEAD_BEEF);
      set_in(1'b0, 1'b0, 5'd0, '0, 5'd8, 5'd8);
      check_eq("rw_p1", readData1, 32'hDEAD_BEEF);
      check_eq("rw_p2", readData2, 32'hDEAD_BEEF);
      set_in(1'b0, 1'b0, 5'd0, '0, 5'd9, 5'd8);
      check_eq("rw_r9", readData1, 32'h0);

      // 3. zero register: no bypass, no storage
      set_in(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
      check_eq("zero_same", readData1, 32'h0);
      check_eq("zero_same_p2", readData2, 32'h0);
      tick();
      for (int c = 0; c < 3; c++) begin
         set_in(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0);
         check_eq("zero_later", readData1, 32'h0);
         tick();
      end

      // 4. bypass
      write_reg(5'd5, 32'h1111_1111);
      write_reg(5'd6, 32'h6060_6060);
      set_in(1'b0, 1'b1, 5'd5, 32'h2222_2222, 5'd5, 5'd6);
      check_eq("byp_p1", readData1, 32'h2222_2222);
      check_eq("byp_p2_old", readData2, 32'h6060_6060);
      tick();
      set_in(1'b0, 1'b1, 5'd9, 32'h9999_0000, 5'd9, 5'd9);
      check_eq("byp_both_p1", readData1, 32'h9999_0000);
      check_eq("byp_both_p2", readData2, 32'h9999_0000);
      tick();

      // 5. write disabled: no update, no bypass
      set_in(1'b0, 1'b0, 5'd5, 32'h3333_3333, 5'd5, 5'd5);
      check_eq("wdis_same", readData1, 32'h2222_2222);
      tick();
      set_in(1'b0, 1'b0, 5'd0, '0, 5'd5, 5'd0);
      check_eq("wdis_after", readData1, 32'h2222_2222);

      // 6. reset beats a simultaneous write; bypass suppressed under reset
      write_reg(5'd7, 32'h0707_0707);
      set_in(1'b1, 1'b1, 5'd7, 32'h7777_7777, 5'd7, 5'd5);
      check_eq("rstw_nobyp", readData1 == 32'h7777_7777 ? 32'h1 : 32'h0, 32'h0);
      tick();
      set_in(1'b0, 1'b0, 5'd0, '0, 5'd7, 5'd5);
      check_eq("rstw_r7", readData1, 32'h0);
      check_eq("rstw_r5", readData2, 32'h0);

      // Randomized traffic against the array model
      for (int c = 0; c < 10000; c++) begin
         set_in(($urandom_range(255) == 0), ($urandom_range(1) == 1),
                reg_idx_t'($urandom_range(31)), word_t'($urandom),
                reg_idx_t'($urandom_range(31)), reg_idx_t'($urandom_range(31)));
         check_eq("rand_p1", readData1, model_read(readReg1));
         check_eq("rand_p2", readData2, model_read(readReg2));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
